// File: rtl/cache_port_arbiter_if.sv
// Bundle between the fetch (I) and load/store (D) requesters, the shared cache port and the arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding core/cache view.
interface cache_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          I_REQ;
    logic [AW-1:0] I_ADDR;
    logic          I_ACK;
    logic [DW-1:0] I_RDATA;

    logic          D_REQ;
    logic          D_WE;
    logic [AW-1:0] D_ADDR;
    logic [DW-1:0] D_WDATA;
    logic          D_ACK;
    logic [DW-1:0] D_RDATA;

    logic [AW-1:0] C_ADDR;
    logic [DW-1:0] C_DIN;
    logic          C_WE;
    logic [DW-1:0] C_DOUT;
    logic          C_RDY;

    logic          ERR;
    logic          ERR_SRC;

    modport slave (
        input  I_REQ, I_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, C_DOUT, C_RDY,
        output I_ACK, I_RDATA, D_ACK, D_RDATA, C_ADDR, C_DIN, C_WE, ERR, ERR_SRC
    );

    modport master (
        output I_REQ, I_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, C_DOUT, C_RDY,
        input  I_ACK, I_RDATA, D_ACK, D_RDATA, C_ADDR, C_DIN, C_WE, ERR, ERR_SRC
    );
endinterface

// File: rtl/cache_port_arbiter.sv
// Shares one cache port between instruction fetch (I) and load/store (D), one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority with D over I.
module cache_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input logic                 CLK,
    input logic                 RST,
    cache_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state_q,   state_d;
    logic          owner_q,   owner_d;
    logic [AW-1:0] addr_q,    addr_d;
    logic [DW-1:0] wdata_q,   wdata_d;
    logic          we_q,      we_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic          i_ack_q,   i_ack_d;
    logic          d_ack_q,   d_ack_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          err_q,     err_d;
    logic          err_src_q, err_src_d;

    logic          any_req;
    logic          gnt_is_d;
    logic          timed_out;
    logic          wait_done;
    logic [DW-1:0] resp_data;

    assign any_req = bus.I_REQ | bus.D_REQ;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    // On contention the port that was not served last wins; a lone requester always wins.
    assign gnt_is_d = (bus.I_REQ && bus.D_REQ) ? ~last_grant_q : bus.D_REQ;
`else
    assign gnt_is_d = bus.D_REQ;
`endif

    // The count of completed WAIT cycles reaching TIMEOUT-1 means this is the TIMEOUT-th WAIT cycle.
    assign timed_out = !bus.C_RDY && (cnt_q == CW'(TIMEOUT - 1));
    assign wait_done = bus.C_RDY || timed_out;
    assign resp_data = bus.C_RDY ? bus.C_DOUT : '0;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        cnt_d     = cnt_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        err_d     = err_q;
        err_src_d = err_src_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                we_d = 1'b0;
                if (any_req) begin
                    owner_d = gnt_is_d;
                    addr_d  = gnt_is_d ? bus.D_ADDR : bus.I_ADDR;
                    wdata_d = gnt_is_d ? bus.D_WDATA : '0;
                    we_d    = gnt_is_d & bus.D_WE;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = gnt_is_d;
`endif
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (wait_done) begin
                    we_d    = 1'b0;
                    state_d = RESP;
                    if (owner_q) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = resp_data;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = resp_data;
                    end
                    if (timed_out) begin
                        err_d     = 1'b1;
                        err_src_d = owner_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                we_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
            err_src_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            err_q     <= err_d;
            err_src_q <= err_src_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // The latched request registers drive the cache directly, so they hold across IDLE.
    assign bus.C_ADDR  = addr_q;
    assign bus.C_DIN   = wdata_q;
    assign bus.C_WE    = we_q;
    assign bus.I_ACK   = i_ack_q;
    assign bus.I_RDATA = i_rdata_q;
    assign bus.D_ACK   = d_ack_q;
    assign bus.D_RDATA = d_rdata_q;
    assign bus.ERR     = err_q;
    assign bus.ERR_SRC = err_src_q;

    a_single_ack: assert property (@(posedge CLK) disable iff (!RST) !(i_ack_q && d_ack_q));
endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Shares the single cache port (ADDR/DIN/WE in, DOUT/RDY out) between the CPU instruction-fetch requester (I) and the load/store requester (D).
- Sits between the RISC-V core and the cache top; sequences one cache transaction at a time.
- Returns each result to the requester that owns it, and flags transactions that hang.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, max WAIT cycles before abort; must be >= 2; counter width is clog2(TIMEOUT+1)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset
- I_REQ  in  1  fetch request; held until I_ACK
- I_ADDR  in  AW  fetch address; stable while I_REQ
- I_ACK  out  1  one-cycle pulse; I_RDATA valid
- I_RDATA  out  DW  fetch data
- D_REQ  in  1  data request; held until D_ACK
- D_WE  in  1  1 = store, 0 = load
- D_ADDR  in  AW  data address
- D_WDATA  in  DW  store data
- D_ACK  out  1  one-cycle pulse; D_RDATA valid (loads)
- D_RDATA  out  DW  load data
- C_ADDR  out  AW  to cache ADDR
- C_DIN  out  DW  to cache DIN
- C_WE  out  1  to cache WE
- C_DOUT  in  DW  from cache DOUT
- C_RDY  in  1  from cache RDY; 1 = transaction complete / cache idle
- ERR  out  1  sticky timeout flag
- ERR_SRC  out  1  owner of the timed-out transaction: 0 = I, 1 = D

Behaviour:
- Reset (RST=0, async): state=IDLE, all outputs 0, owner=0, timeout counter=0, ERR=0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If no request, C_WE=0 and C_ADDR/C_DIN hold their last values.
  - If any request, grant and latch owner, addr, wdata and we into internal regs; go to ISSUE.
- Arbitration without macro: fixed priority, D beats I.
- ISSUE:
  - Exactly 1 cycle. C_ADDR/C_DIN/C_WE driven from the latched regs; counter cleared.
  - Lets the cache see the new address before RDY is sampled. Go to WAIT.
- WAIT:
  - C_* held stable from the latched regs; counter increments each cycle.
  - C_RDY=1: capture C_DOUT into the owner's RDATA register; go to RESP.
  - Counter reaches TIMEOUT with C_RDY=0: set ERR=1 and ERR_SRC=owner; go to RESP. Data for a timed-out transaction is 0.
- RESP:
  - 1 cycle. Pulse the owner's ACK; C_WE=0. Go to IDLE.
  - ACK-to-next-grant gap is therefore at least 1 cycle, so a requester can drop REQ after ACK without a re-grant.
- Latency: grant cycle + ISSUE + n WAIT cycles + RESP. With C_RDY=1 on the first WAIT cycle, ACK is high in the 4th cycle after REQ is sampled in IDLE.
- RDATA registers hold their value until that port's next ACK.
- Store ACK: D_RDATA is updated with C_DOUT, which is don't-care.
- Simultaneous I_REQ and D_REQ: only one is granted; the other waits in IDLE with no loss.
- Requester changes ADDR mid-transaction: ignored, because the latched copy is used.
- REQ deasserted before ACK: the transaction still completes; the ACK is still pulsed and is dropped by the requester.
- ERR: cleared only by reset; never blocks further transactions.
- Reset mid-WAIT: immediate return to IDLE with C_WE=0 and no ACK. The cache is reset by the same RST.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. A last_grant reg (reset 0 = I) is updated at each grant.
  - On simultaneous requests, the port not granted last wins.
  - A single requester is always granted.
- Undefined: fixed priority with D over I; no last_grant reg.

Test Plan:
- Single I fetch: I_ADDR=0x100 with C_RDY=1 on the first WAIT cycle, C_DOUT=0xDEADBEEF -> C_WE=0, I_ACK high 4 cycles after REQ, I_RDATA=0xDEADBEEF, D_ACK never pulses.
- D store: D_ADDR=0x40, D_WDATA=0x12345678, D_WE=1, C_RDY delayed 5 cycles -> C_ADDR/C_DIN/C_WE stable through all of ISSUE and WAIT, single D_ACK pulse, C_WE=0 in RESP.
- Contention: I_REQ and D_REQ both rise in the same cycle.
  - Without macro: D is served first, then I.
  - With ARB_ROUND_ROBIN_EN and back-to-back held requests: grants alternate D, I, D (from reset last_grant=I, so D is granted first).
- Timeout: TIMEOUT=8, C_RDY held 0 on a D load -> D_ACK after 8 WAIT cycles, D_RDATA=0, ERR=1, ERR_SRC=1. A following I fetch still completes with ERR still 1.
- Address change: I_ADDR changed from 0x100 to 0x200 during WAIT -> C_ADDR stays 0x100.
- Reset mid-WAIT: RST pulled low -> all outputs 0 asynchronously, no ACK. After release with I_REQ still high, a fresh transaction completes normally.
